// File: rtl/csr_timer_unit.sv
`default_nettype none
//==============================================================================
// Module      : csr_timer_unit
// Description : Constant-frequency timer for the LoongArch CSR file. Holds
//               TID/TCFG/TVAL/TICLR and the 64-bit stable counter, and raises
//               the level timer interrupt. Build option: TIMER_PRESCALE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module csr_timer_unit #(
  parameter logic [31:0] TID_INIT = 32'h0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        csr_hit,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] counter_id
);

  localparam logic [13:0] C_NUM_TID   = 14'h40;
  localparam logic [13:0] C_NUM_TCFG  = 14'h41;
  localparam logic [13:0] C_NUM_TVAL  = 14'h42;
  localparam logic [13:0] C_NUM_TICLR = 14'h44;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] tid_q;
  logic [31:0] tid_d;
  logic [31:0] tcfg_q;
  logic [31:0] tcfg_d;
  logic [31:0] timer_cnt_q;
  logic        pending_q;
  logic [63:0] stable_cnt_q;

  logic        w_wr_tid;
  logic        w_wr_tcfg;
  logic        w_clr;
  logic [31:0] w_tcfg_new;
  logic        w_tick;
  logic        w_expire;

  assign w_wr_tid   = csr_we && (csr_num == C_NUM_TID);
  assign w_wr_tcfg  = csr_we && (csr_num == C_NUM_TCFG);
  assign w_clr      = csr_we && (csr_num == C_NUM_TICLR) && csr_wmask[0] && csr_wvalue[0];
  assign w_tcfg_new = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q);

  assign tid_d  = w_wr_tid ? ((csr_wmask & csr_wvalue) | (~csr_wmask & tid_q)) : tid_q;
  assign tcfg_d = w_wr_tcfg ? w_tcfg_new : tcfg_q;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned      C_PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_PSC_W-1:0] C_PSC_LAST = C_PSC_W'(PRESCALE - 1);

  logic [C_PSC_W-1:0] psc_q;

  assign w_tick = (state_q == S_RUN) && (psc_q == C_PSC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psc_q <= '0;
    end else if (w_wr_tcfg || (state_q != S_RUN) || w_tick) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_q + 1'b1;
    end
  end
`else
  // PRESCALE of 0 is not a legal configuration; otherwise every RUN cycle ticks.
  assign w_tick = (state_q == S_RUN) && (PRESCALE != 0);
`endif

  // A TCFG write pre-empts the tick, including its expiry.
  assign w_expire = w_tick && !w_wr_tcfg && (timer_cnt_q == 32'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q        <= TID_INIT;
      tcfg_q       <= 32'd0;
      timer_cnt_q  <= 32'd0;
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      stable_cnt_q <= 64'd0;
    end else begin
      tid_q        <= tid_d;
      tcfg_q       <= tcfg_d;
      stable_cnt_q <= stable_cnt_q + 64'd1;

      if (w_expire) begin
        pending_q <= 1'b1;
      end else if (w_clr) begin
        pending_q <= 1'b0;
      end

      if (w_wr_tcfg) begin
        timer_cnt_q <= {w_tcfg_new[31:2], 2'b00};
        state_q     <= w_tcfg_new[0] ? S_RUN : S_IDLE;
      end else if (w_tick) begin
        if (timer_cnt_q != 32'd0) begin
          timer_cnt_q <= timer_cnt_q - 32'd1;
        end else if (tcfg_q[1]) begin
          timer_cnt_q <= {tcfg_q[31:2], 2'b00};
        end else begin
          state_q <= S_DONE;
        end
      end
    end
  end

  always_comb begin
    csr_hit    = 1'b0;
    csr_rvalue = 32'd0;
    case (csr_num)
      C_NUM_TID: begin
        csr_hit    = 1'b1;
        csr_rvalue = tid_q;
      end
      C_NUM_TCFG: begin
        csr_hit    = 1'b1;
        csr_rvalue = tcfg_q;
      end
      C_NUM_TVAL: begin
        csr_hit    = 1'b1;
        csr_rvalue = timer_cnt_q;
      end
      C_NUM_TICLR: begin
        csr_hit    = 1'b1;
        csr_rvalue = 32'd0;
      end
      default: begin
        csr_hit    = 1'b0;
        csr_rvalue = 32'd0;
      end
    endcase
  end

  assign timer_int  = pending_q;
  assign stable_cnt = stable_cnt_q;
  assign counter_id = tid_q;

endmodule
`default_nettype wire
